// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Purpose : Shared encodings for the modulo counter: the mode field values and
//           the one-shot FSM state enum. Also holds a small helper that groups
//           the two wrap encodings together.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package counter_pkg;

  // Counter behaviour selected by the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_WRAP_RSV = 2'd3   // reserved code, behaves exactly like MODE_WRAP
  } mode_e;

  // One-shot FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for both encodings that wrap at the boundary.
  function automatic logic is_wrap(input mode_e m);
    return (m == MODE_WRAP) || (m == MODE_WRAP_RSV);
  endfunction

endpackage : counter_pkg

// File: rtl/cnt_prescale.sv
// -----------------------------------------------------------------------------
// cnt_prescale
// Purpose : Divides the enabled clock cycles by PRESCALE. An internal phase
//           counter runs 0..PRESCALE-1 while en is high and holds while en is
//           low, so the phase survives a pause. tick is high whenever the phase
//           sits at PRESCALE-1; the consumer qualifies it with its own enable.
// Ports   : clk     - clock, rising edge
//           reset   - asynchronous active-low reset (phase -> 0)
//           en      - advance the phase this cycle
//           restart - synchronous return of the phase to 0 (wins over en)
//           tick    - phase is at its last value
// -----------------------------------------------------------------------------
module cnt_prescale #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  // With PRESCALE=1 a single bit stuck at 0 gives LAST=0, so tick is always 1.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] phase_q;
  logic [CW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick = (phase_q == LAST);

endmodule : cnt_prescale

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Purpose : Up/down modulo counter with wrap, saturate and one-shot behaviour,
//           optional prescaler, synchronous clear/load and sticky overflow.
// Params  : WIDTH    - counter width (2..32)
//           MODULUS  - count range 0..MODULUS-1 (2..2**WIDTH)
//           PRESCALE - enabled input cycles per count step (1 = every cycle)
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous active-low reset
//           en       - count enable (also gates the prescaler)
//           up       - 1 = increment, 0 = decrement
//           mode     - 0 wrap, 1 saturate, 2 one-shot, 3 wrap
//           clr      - synchronous clear (highest priority)
//           load     - synchronous load of load_val (clamped to MODULUS-1)
//           load_val - load data
//           value    - registered count
//           tc       - registered one-cycle terminal-count pulse
//           ovf      - sticky boundary-crossing flag, cleared by clr
//           running  - one-shot mode: FSM in RUN; other modes: registered en
// -----------------------------------------------------------------------------
module mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  mode_e            mode_s;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;      // sitting at a boundary reached by a saturating step
  logic             running_q, running_d;
  logic             rdy_q;             // low for the first edge after reset release

  logic             pre_en;
  logic             pre_restart;
  logic             pre_tick;
  logic             step_req;
  logic             step_ok;
  logic             bnd;
  logic [WIDTH-1:0] load_clamped;

  assign mode_s = mode_e'(mode);

  // ---------------------------------------------------------------------------
  // Reset-release qualifier: the first rising edge after reset only arms this
  // flop, so neither the prescaler nor the counter can move before the second.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign pre_en      = en & rdy_q;
  assign pre_restart = clr | load;

  cnt_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .en      (pre_en),
    .restart (pre_restart),
    .tick    (pre_tick)
  );

  // ---------------------------------------------------------------------------
  // Step qualification
  // ---------------------------------------------------------------------------
  assign step_req = pre_en & pre_tick;

  // The FSM only gates stepping in one-shot mode; elsewhere it is a bystander.
  assign step_ok  = step_req & ((mode_s != MODE_ONESHOT) || (state_q == ST_RUN));

  assign bnd      = up ? (value_q == MAX_V) : (value_q == '0);

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. load re-arms from any state (IDLE and DONE are the
  // interesting cases); a boundary step in one-shot mode finishes the run.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_RUN;
    end else if (step_ok && bnd && (mode_s == MODE_ONESHOT)) begin
      state_d = ST_DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and datapath next state. Everything computed here lands in a
  // flop, so the module outputs carry no combinational path from the inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    value_d   = value_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    sat_d     = sat_q;
    running_d = (mode_s == MODE_ONESHOT) ? (state_d == ST_RUN) : en;

    if (clr) begin
      value_d = '0;
      ovf_d   = 1'b0;
      sat_d   = 1'b0;
    end else if (load) begin
      value_d = load_clamped;
      sat_d   = 1'b0;
    end else if (step_ok) begin
      if (!bnd) begin
        value_d = up ? (value_q + ONE) : (value_q - ONE);
        sat_d   = 1'b0;
      end else begin
        ovf_d = 1'b1;
        if (is_wrap(mode_s)) begin
          value_d = up ? '0 : MAX_V;
          tc_d    = 1'b1;
          sat_d   = 1'b0;
        end else if (mode_s == MODE_SAT) begin
          // Value holds; only the first push against the limit pulses tc.
          tc_d  = ~sat_q;
          sat_d = 1'b1;
        end else begin
          // One-shot: value holds at the boundary, FSM goes to DONE.
          tc_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q   <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      sat_q     <= sat_d;
      running_q <= running_d;
    end
  end

  assign value   = value_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign running = running_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Purpose : Directed self-checking bench for mod_counter. Three instances share
//           the stimulus: full-range 8-bit, MODULUS=10, and PRESCALE=4. Inputs
//           are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       en       = 1'b0;
  logic       up       = 1'b1;
  logic [1:0] mode     = 2'd0;
  logic       clr      = 1'b0;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] v256, v10, vp4;
  logic       tc256, ovf256, run256;
  logic       tc10, ovf10, run10;
  logic       tcp4, ovfp4, runp4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8)) u_d256 (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val),
    .value(v256), .tc(tc256), .ovf(ovf256), .running(run256)
  );

  mod_counter #(.WIDTH(8), .MODULUS(10)) u_d10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val),
    .value(v10), .tc(tc10), .ovf(ovf10), .running(run10)
  );

  mod_counter #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val),
    .value(vp4), .tc(tcp4), .ovf(ovfp4), .running(runp4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // Hand-computed expectations.
  int s2_v  [5] = '{2, 1, 0, 9, 8};
  int s2_tc [5] = '{0, 0, 0, 1, 0};
  int s3_v  [5] = '{8, 9, 9, 9, 9};
  int s3_tc [5] = '{0, 0, 1, 0, 0};
  int s3_ov [5] = '{0, 0, 1, 1, 1};
  int s4_v  [6] = '{6, 7, 8, 9, 9, 9};
  int s4_tc [6] = '{0, 0, 0, 0, 1, 0};
  int s4_rn [6] = '{1, 1, 1, 1, 0, 0};
  int s5_en [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int s5_v  [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2};

  initial begin
    // ---------------- reset state ----------------
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_value256", v256, 0);
    check_eq("rst_tc256", tc256, 0);
    check_eq("rst_ovf256", ovf256, 0);
    check_eq("rst_running256", run256, 0);
    check_eq("rst_value10", v10, 0);
    check_eq("rst_valuep4", vp4, 0);

    // ---------------- full-range wrap up count ----------------
    reset = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      check_eq($sformatf("wrap256_v_e%0d", k), v256, (k <= 1) ? 0 : ((k - 1) % 256));
      check_eq($sformatf("wrap256_tc_e%0d", k), tc256, (k == 257) ? 1 : 0);
      check_eq($sformatf("wrap256_ovf_e%0d", k), ovf256, (k >= 257) ? 1 : 0);
    end

    // ---------------- MOD10 down wrap from 3, then clamped load ----------------
    up = 1'b0; load = 1'b1; load_val = 8'd3;
    @(negedge clk);
    check_eq("d10_load3", v10, 3);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("d10_down_v%0d", i), v10, s2_v[i]);
      check_eq($sformatf("d10_down_tc%0d", i), tc10, s2_tc[i]);
    end
    load = 1'b1; load_val = 8'd200;
    @(negedge clk);
    check_eq("d10_load200_clamp", v10, 9);
    check_eq("d10_load200_tc", tc10, 0);

    // ---------------- MOD10 saturate up from 7 ----------------
    load = 1'b0; clr = 1'b1; mode = 2'd1; up = 1'b1;
    @(negedge clk);
    check_eq("sat_pre_clr_v", v10, 0);
    check_eq("sat_pre_clr_ovf", ovf10, 0);
    clr = 1'b0; load = 1'b1; load_val = 8'd7;
    @(negedge clk);
    check_eq("sat_load7", v10, 7);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("sat_v%0d", i), v10, s3_v[i]);
      check_eq($sformatf("sat_tc%0d", i), tc10, s3_tc[i]);
      check_eq($sformatf("sat_ovf%0d", i), ovf10, s3_ov[i]);
    end
    clr = 1'b1;
    @(negedge clk);
    check_eq("sat_clr_v", v10, 0);
    check_eq("sat_clr_ovf", ovf10, 0);
    check_eq("sat_clr_tc", tc10, 0);

    // ---------------- MOD10 one-shot ----------------
    clr = 1'b0; mode = 2'd2;
    repeat (2) @(negedge clk);
    check_eq("os_idle_v", v10, 0);
    check_eq("os_idle_running", run10, 0);
    load = 1'b1; load_val = 8'd5;
    @(negedge clk);
    check_eq("os_load5_v", v10, 5);
    check_eq("os_load5_running", run10, 1);
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("os_v%0d", i), v10, s4_v[i]);
      check_eq($sformatf("os_tc%0d", i), tc10, s4_tc[i]);
      check_eq($sformatf("os_running%0d", i), run10, s4_rn[i]);
    end
    load = 1'b1; load_val = 8'd2;
    @(negedge clk);
    check_eq("os_reload2_v", v10, 2);
    check_eq("os_reload2_running", run10, 1);
    load = 1'b0;
    @(negedge clk);
    check_eq("os_restart_v3", v10, 3);
    @(negedge clk);
    check_eq("os_restart_v4", v10, 4);

    // ---------------- PRESCALE=4 with a 3-cycle pause ----------------
    mode = 2'd0; up = 1'b1; clr = 1'b1;
    @(negedge clk);
    check_eq("ps_clr_v", vp4, 0);
    clr = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = s5_en[i][0];
      @(negedge clk);
      check_eq($sformatf("ps_v%0d", i), vp4, s5_v[i]);
    end
    en = 1'b1;

    // ---------------- clr+load together, down wrap at 0 ----------------
    clr = 1'b1; load = 1'b1; load_val = 8'd7;
    @(negedge clk);
    check_eq("clr_over_load_v10", v10, 0);
    check_eq("clr_over_load_vp4", vp4, 0);
    clr = 1'b0; load = 1'b0; up = 1'b0;
    @(negedge clk);
    check_eq("d10_down0_v", v10, 9);
    check_eq("d10_down0_tc", tc10, 1);
    check_eq("d10_down0_ovf", ovf10, 1);
    up = 1'b1;
    @(negedge clk);
    check_eq("d10_up9_v", v10, 0);
    check_eq("d10_up9_tc", tc10, 1);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_v10", v10, 2);
    check_eq("pre_rst_ovf10", ovf10, 1);
    check_eq("pre_rst_running10", run10, 1);

    // ---------------- asynchronous reset mid-cycle ----------------
    #2 reset = 1'b0;
    #1;
    check_eq("arst_v10", v10, 0);
    check_eq("arst_tc10", tc10, 0);
    check_eq("arst_ovf10", ovf10, 0);
    check_eq("arst_running10", run10, 0);
    check_eq("arst_v256", v256, 0);
    check_eq("arst_running256", run256, 0);
    check_eq("arst_vp4", vp4, 0);

    // ---------------- reset release latency ----------------
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_edge1_v10", v10, 0);
    @(negedge clk);
    check_eq("rel_edge2_v10", v10, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1; legal 2..2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: input cycles per count step; 1 = no prescaling.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserted at 0.
REQ-006 en  in  1  count enable; gates the prescaler and the counter.
REQ-007 up  in  1  direction; 1 = increment, 0 = decrement.
REQ-008 mode  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = wrap (reserved).
REQ-009 clr  in  1  synchronous clear to 0.
REQ-010 load  in  1  synchronous load of load_val.
REQ-011 load_val  in  WIDTH  load data.
REQ-012 value  out  WIDTH  registered count.
REQ-013 tc  out  1  registered terminal-count pulse, one cycle wide.
REQ-014 ovf  out  1  sticky boundary-crossing flag.
REQ-015 running  out  1  1 while the one-shot FSM is in RUN; otherwise reflects en.

Function
REQ-016 Priority per cycle SHALL be clr > load > step; only one applies.
REQ-017 A step SHALL occur on a cycle where en=1 and the prescaler tick is 1; with PRESCALE=1 the tick is always 1.
REQ-018 clr SHALL set value to 0, clear ovf, reset the prescaler and force the FSM to IDLE; tc=0 that cycle.
REQ-019 load SHALL set value to min(load_val, MODULUS-1), reset the prescaler and move the FSM to RUN; ovf unchanged.
REQ-020 Up step below MODULUS-1: value+1; down step above 0: value-1; the next value is visible one cycle after the step edge.
REQ-021 Boundary = up step at MODULUS-1 or down step at 0.
REQ-022 Wrap mode at boundary: value goes to 0 (up) or MODULUS-1 (down); tc pulses; ovf sets.
REQ-023 Saturate mode at boundary: value holds; tc pulses only on the first boundary step after leaving the boundary value; ovf sets.
REQ-024 One-shot FSM states are IDLE, RUN and DONE; steps SHALL occur only in RUN.
REQ-025 One-shot transitions: IDLE->RUN on load; RUN->DONE on a boundary step, where value holds and tc pulses; DONE->RUN on load; any state->IDLE on clr.
REQ-026 Outside one-shot mode, the FSM state SHALL be ignored for stepping.
REQ-027 Mode change mid-count SHALL take effect on the next step without altering value.
REQ-028 Prescaler SHALL count 0..PRESCALE-1 while en=1, tick at PRESCALE-1 and hold when en=0.
REQ-029 All arithmetic SHALL be modulo-free and explicitly bounded; no out-of-range value is ever visible.

Reset
REQ-030 While reset=0: value=0, tc=0, ovf=0, FSM=IDLE, prescaler=0, running=0, asynchronously.
REQ-031 Deassertion SHALL take effect at the next rising clk; the first step is allowed no earlier than the second edge after deassertion.

Structure
REQ-032 Package counter_pkg SHALL hold the mode encodings and the FSM state enum.
REQ-033 Prescaler SHALL be sub-module cnt_prescale (parameter PRESCALE; ports clk, reset, en, restart, tick).
REQ-034 All outputs SHALL be driven directly from flops.

Verification
REQ-035 WIDTH=8, MODULUS=256, wrap, up, en=1 from reset -> value 0..255, then 0; tc high the cycle value shows 0 after 255; ovf=1 thereafter.
REQ-036 MODULUS=10, down, wrap, load 3 -> 3,2,1,0,9; one tc pulse; load_val=200 -> value 9.
REQ-037 MODULUS=10, saturate, up from 7 -> 8,9,9,9; exactly one tc pulse; clr -> value 0, ovf 0.
REQ-038 One-shot, MODULUS=10, load 5, up -> 6..9, then DONE, value 9, running=0; a second load 2 restarts counting.
REQ-039 PRESCALE=4, up, en toggled 0 for 3 cycles mid-count -> value advances only every 4 enabled cycles; prescaler phase is preserved across the pause.
REQ-040 reset=0 asserted mid-count, asynchronous to clk -> all outputs 0 before the next clk edge; clr and load asserted together -> value 0.
